// File: rtl/hamming_weight_sched.sv
// hamming_weight_sched: round-robin share of one 8-bit popcount unit between two requesters for multi-byte words
module HammingWeight_8bit (
    input  logic [7:0] data,
    output logic [3:0] weight
);
    // ripple sum of the eight bits
    always_comb begin
        weight = '0;
        for (int i = 0; i < 8; i++) weight = weight + {3'b000, data[i]};
    end
endmodule

module hamming_weight_sched #(
    parameter int NBYTES = 4,
    parameter int CW = $clog2(8*NBYTES+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [8*NBYTES-1:0] data0,
    input  logic              req1,
    input  logic [8*NBYTES-1:0] data1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              result_valid,
    output logic              result_id,
    output logic [CW-1:0]     result
);
    localparam int W = 8*NBYTES;
    localparam logic [CW-1:0] LAST = CW'(NBYTES-1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  sh;
    logic [CW-1:0] acc, cnt, sum;
    logic [3:0]    pc;
    logic          cur_id, last_id, pick, any;

    HammingWeight_8bit u_pc (.data(sh[7:0]), .weight(pc));

    // arbitration: a tie goes to whoever was not served last; DONE accepts too so jobs run back-to-back
    always_comb begin
        any  = req0 | req1;
        pick = (req0 & req1) ? ~last_id : req1;
        sum  = acc + CW'(pc);
    end

    // scheduler FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sh           <= '0;
            acc          <= '0;
            cnt          <= '0;
            cur_id       <= 1'b0;
            last_id      <= 1'b1;
            gnt          <= 2'b00;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_id    <= 1'b0;
            result       <= '0;
        end else begin
            gnt          <= 2'b00;
            result_valid <= 1'b0;
            case (state)
                RUN: begin
                    acc <= sum;
                    sh  <= sh >> 8;
                    cnt <= cnt + ONE;
                    if (cnt == LAST) begin
                        result       <= sum;
                        result_id    <= cur_id;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: begin
                    if (any) begin
                        sh      <= pick ? data1 : data0;
                        cur_id  <= pick;
                        last_id <= pick;
                        acc     <= '0;
                        cnt     <= '0;
                        gnt     <= pick ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_weight_sched.sv
// tb_hamming_weight_sched: directed scoreboard bench for the shared popcount scheduler
module tb_hamming_weight_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] data0 = '0, data1 = '0;
    logic [1:0]  gnt;
    logic        busy, result_valid, result_id;
    logic [5:0]  result;

    int passed = 0, total = 0, cyc = 0;
    logic [6:0] sb[$];
    int rv_cyc[$];
    int prev;

    hamming_weight_sched #(.NBYTES(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt(gnt), .busy(busy), .result_valid(result_valid),
        .result_id(result_id), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt !== 2'b00) return;
        end
        chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    // compare every result pulse against the scoreboard head
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_cyc.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("result", 32'({result_id, result}), 32'(sb.pop_front()));
        end
    end

    initial begin
        // reset idle
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_idle", 32'({gnt, busy, result_valid, result}), 32'd0);
        end
        // single request
        req0 = 1'b1; data0 = 32'h0000_00FF; sb.push_back({1'b0, 6'd8});
        wait_gnt();
        chk("single_gnt", 32'(gnt), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        tick();
        chk("single_gnt_pulse", 32'(gnt), 32'd0);
        repeat (3) tick();
        chk("single_rv", 32'({busy, result_valid}), 32'd3);
        tick();
        chk("single_busy_fall", 32'({busy, result_valid}), 32'd0);
        // width extremes
        req1 = 1'b1; data1 = 32'hFFFF_FFFF; sb.push_back({1'b1, 6'd32});
        wait_gnt();
        chk("ext_gnt_ones", 32'(gnt), 32'd2);
        req1 = 1'b0;
        repeat (5) tick();
        req1 = 1'b1; data1 = 32'h0000_0000; sb.push_back({1'b1, 6'd0});
        wait_gnt();
        chk("ext_gnt_zero", 32'(gnt), 32'd2);
        req1 = 1'b0;
        repeat (5) tick();
        chk("ext_zero_result", 32'({result_id, result}), 32'h40);
        // tie and alternation from reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 32'h0101_0101; data1 = 32'h7F00_000F;
        for (int i = 0; i < 4; i++) sb.push_back(i[0] ? {1'b1, 6'd11} : {1'b0, 6'd4});
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt();
            chk("tie_gnt", 32'(gnt), i[0] ? 32'd2 : 32'd1);
            if (i > 0) chk("tie_spacing", 32'(cyc - prev), 32'd5);
            prev = cyc;
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        tick();
        chk("tie_gnt_pulse", 32'(gnt), 32'd0);
        repeat (5) tick();
        // reset mid-job
        req0 = 1'b1; data0 = 32'hFFFF_0000;
        wait_gnt();
        chk("abort_gnt", 32'(gnt), 32'd1);
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("abort_outputs", 32'({gnt, busy, result_valid, result_id, result}), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("abort_quiet", 32'({gnt, busy, result_valid}), 32'd0);
        req1 = 1'b1; data1 = 32'h8000_0001; sb.push_back({1'b1, 6'd2});
        wait_gnt();
        chk("abort_next_gnt", 32'(gnt), 32'd2);
        req1 = 1'b0;
        repeat (5) tick();
        // sustained single requester
        rv_cyc.delete();
        req1 = 1'b1; data1 = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) sb.push_back({1'b1, 6'd16});
        for (int i = 0; i < 3; i++) begin
            wait_gnt();
            chk("sust_gnt", 32'(gnt), 32'd2);
            if (i == 2) req1 = 1'b0;
        end
        repeat (6) tick();
        chk("sust_pulses", 32'(rv_cyc.size()), 32'd3);
        if (rv_cyc.size() == 3) begin
            chk("sust_gap1", 32'(rv_cyc[1] - rv_cyc[0]), 32'd5);
            chk("sust_gap2", 32'(rv_cyc[2] - rv_cyc[1]), 32'd5);
        end
        chk("sust_idle", 32'({gnt, busy, result_valid}), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
